// File: rtl/result_reader.sv
// Streams every word of the W*W result memory out through a 2-entry FIFO,
// optionally clamping negative words to zero (ReLU).
module result_reader #(
  parameter int W = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        relu_en,
  output logic        rd_en,
  output logic [9:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, no reads issued
  // READ  | issuing reads 0..DEPTH-1 as FIFO space allows
  // DRAIN | last read issued, emptying FIFO until out_last transfers
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam int DEPTH = W * W;
  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  state_t      state, state_nxt;
  logic [9:0]  addr;
  logic        relu_q;
  logic        inflight;
  logic        inflight_last;
  logic [31:0] mem0, mem1;
  logic        last0, last1;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        pop;
  logic [1:0]  pending;
  logic [31:0] word;

  assign pop       = out_valid & out_ready;
  // The word popped this cycle frees its slot in time for a read issued now,
  // which is what allows one word per cycle under continuous out_ready.
  assign pending   = count - {1'b0, pop} + {1'b0, inflight};
  assign word      = (relu_q && rd_data[31]) ? 32'd0 : rd_data;
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? mem1 : mem0;
  assign out_last  = rd_ptr ? last1 : last0;
  assign rd_addr   = addr;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        if (pending < 2'd2) begin
          rd_en = 1'b1;
          if (addr == LAST_ADDR) state_nxt = DRAIN;
        end
      end
      DRAIN: if (pop && out_last) state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      relu_q        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      mem0          <= '0;
      mem1          <= '0;
      last0         <= 1'b0;
      last1         <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        addr   <= '0;
        relu_q <= relu_en;
      end else if (rd_en && addr != LAST_ADDR) begin
        addr <= addr + 10'd1;
      end
      inflight      <= rd_en;
      inflight_last <= rd_en && (addr == LAST_ADDR);
      if (inflight) begin
        if (wr_ptr) begin
          mem1  <= word;
          last1 <= inflight_last;
        end else begin
          mem0  <= word;
          last0 <= inflight_last;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: expected words are queued at start and
// compared against each transfer, with protocol checks on every cycle.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;

  result_reader #(.W(28)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic [31:0] mem [784];
  exp_t        sbq [$];

  int checks = 0;
  int failures = 0;

  // monitor state
  bit          mon_en = 0;
  bit          cons = 0;
  int          cyc = 0;
  int          words = 0;
  int          done_cnt = 0;
  int          issued = 0;
  int          exp_addr = 0;
  int          first_rd_cyc = -1;
  int          first_val_cyc = -1;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  bit          last_xfer_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'h0BAD_0BAD;

  always @(negedge clk) begin
    if (mon_en) begin
      int   outstanding;
      bit   pop;
      exp_t e;
      cyc++;
      pop = out_valid && out_ready;
      outstanding = issued - words;
      if (rd_en) begin
        chk("rd_addr", {22'd0, rd_addr}, exp_addr);
        chk("rd_gate", {31'd0, (outstanding - int'(pop)) < 2}, 1);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        exp_addr++;
        issued++;
      end
      if (out_valid && first_val_cyc < 0) begin
        first_val_cyc = cyc;
        chk("latency", cyc - first_rd_cyc, 2);
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (cons && words > 0 && words < 784) chk("back_to_back", {31'd0, out_valid}, 1);
      chk("done", {31'd0, done}, {31'd0, last_xfer_prev});
      if (done) done_cnt++;
      last_xfer_prev = 0;
      if (pop) begin
        if (sbq.size() == 0) begin
          chk("extra_word", out_data, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          last_xfer_prev = e.last;
        end
        words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({tag, "_rd_addr"}, {22'd0, rd_addr}, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  task automatic run(input logic relu, input bit rand_ready, input bit pulse_start,
                     input bit toggle_relu, input int reset_at);
    exp_t e;
    int   guard;
    bit   pulsed;
    sbq.delete();
    for (int i = 0; i < 784; i++) begin
      e.d    = (relu && mem[i][31]) ? 32'd0 : mem[i];
      e.last = (i == 783);
      sbq.push_back(e);
    end
    words = 0; done_cnt = 0; issued = 0; exp_addr = 0; cyc = 0;
    first_rd_cyc = -1; first_val_cyc = -1;
    prev_stall = 0; last_xfer_prev = 0; cons = !rand_ready;
    @(posedge clk); #1;
    start = 1'b1;
    relu_en = relu;
    out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (toggle_relu) relu_en = ~relu;
    out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    #3;
    chk("first_rd_en", {31'd0, rd_en}, 1);
    chk("first_rd_addr", {22'd0, rd_addr}, 0);
    guard = 0;
    pulsed = 0;
    while (done_cnt == 0 && guard < 6000) begin
      @(posedge clk); #1;
      guard++;
      out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (start) start = 1'b0;
      if (pulse_start && !pulsed && words >= 100) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (reset_at >= 0 && words >= reset_at) begin
        rst = 1'b0;
        mon_en = 0;
        #1;
        chk_zero_outs("mid_reset");
        sbq.delete();
        return;
      end
    end
    chk("timeout", {31'd0, guard < 6000}, 1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
    chk("busy_after", {31'd0, busy}, 0);
    chk("word_count", words, 784);
    chk("done_count", done_cnt, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    bit saw_rd;
    #2;
    chk_zero_outs("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset_hold");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 0);

    // full stream, identity data
    for (int i = 0; i < 784; i++) mem[i] = i;
    run(1'b0, 0, 0, 0, -1);

    // signed data with the two ReLU probe words
    for (int i = 0; i < 784; i++) mem[i] = (i % 3 == 0) ? -i : i * 7;
    mem[5] = 32'hFFFF_FFF0;
    mem[6] = 32'h0000_0010;
    run(1'b1, 0, 0, 1, -1);
    run(1'b0, 0, 0, 1, -1);

    // random backpressure with an ignored start at word 100
    run(1'b0, 1, 1, 1, -1);

    // reset at word 300, then a clean restart
    run(1'b0, 0, 0, 0, 300);
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset_held");
    rst = 1'b1;
    saw_rd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rd_en || out_valid) saw_rd = 1;
    end
    chk("no_rd_after_reset", {31'd0, saw_rd}, 0);
    run(1'b1, 0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
